// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Frame: LEN lo, LEN hi, N*4 data bytes (LSB first), checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_LEN0 = 3'd0,
    LD_LEN1 = 3'd1,
    LD_DATA = 3'd2,
    LD_CSUM = 3'd3,
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_t;

  localparam int HDR_BYTES = 2;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] LANE_LAST = 2'd3;

endpackage

// File: rtl/imem_word_packer.sv
// Packs four bytes, LSB first, into a 32-bit word.
// word_valid pulses with the fourth byte; word is valid with it.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] sr;

  assign word_valid = byte_valid && (lane == LANE_LAST);
  assign word = {byte_data, sr};

  // lane counter and low-lane holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= 2'd0;
      sr   <= 24'd0;
    end else if (clear) begin
      lane <= 2'd0;
      sr   <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      unique case (lane)
        2'd0: sr[7:0]   <= byte_data;
        2'd1: sr[15:8]  <= byte_data;
        2'd2: sr[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed image into instruction memory and
// holds the CPU in reset until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int CW = ADDR_W + 1;

  ld_state_t        state;
  logic [7:0]       len_lo;
  logic [7:0]       acc;
  logic [CNT_W-1:0] n_words;
  logic [CW-1:0]    wcnt;

  logic             take;
  logic             data_byte;
  logic             word_done;
  logic [31:0]      word_next;
  logic [CNT_W-1:0] n_hdr;
  logic             too_big;
  logic             last_word;

  assign take = in_valid && in_ready && !rearm;
  assign data_byte = take && (state == LD_DATA);
  assign n_hdr = CNT_W'({in_data, len_lo});
  assign too_big = 32'(n_hdr) > (32'd1 << ADDR_W);
  assign last_word =
    (32'(wcnt) + 32'd1) == 32'(n_words);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (rearm),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .word_valid (word_done),
    .word       (word_next)
  );

  // frame FSM, checksum, word counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LD_LEN0;
      len_lo    <= 8'd0;
      acc       <= 8'd0;
      n_words   <= '0;
      wcnt      <= '0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (rearm) begin
        state     <= LD_LEN0;
        acc       <= 8'd0;
        wcnt      <= '0;
        in_ready  <= 1'b1;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        err       <= 1'b0;
      end else if (take) begin
        unique case (state)
          LD_LEN0: begin
            len_lo <= in_data;
            acc    <= acc ^ in_data;
            state  <= LD_LEN1;
          end
          LD_LEN1: begin
            n_words <= n_hdr;
            acc     <= acc ^ in_data;
            if (n_hdr == '0) begin
              state <= LD_CSUM;
            end else if (too_big) begin
              state    <= LD_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= LD_DATA;
            end
          end
          LD_DATA: begin
            acc <= acc ^ in_data;
            if (word_done) begin
              mem_we    <= 1'b1;
              mem_wdata <= word_next;
              mem_addr  <= wcnt[ADDR_W-1:0];
              wcnt      <= wcnt + 1'b1;
              if (last_word) state <= LD_CSUM;
            end
          end
          LD_CSUM: begin
            in_ready <= 1'b0;
            if (in_data == acc) begin
              state     <= LD_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus
// rearm and mid-load reset sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rearm = 1'b0;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  int nchk = 0;
  int nerr = 0;

  imem_loader #(.ADDR_W(15), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rearm     (rearm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          bad_we = 0;
  int          bad_addr = 0;
  logic [31:0] mdl [0:7];
  int          wr_cyc [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  // memory model fed by the write port
  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc[wr_cnt[5:0]] <= cyc;
      if (mem_addr < 15'd8) mdl[mem_addr[2:0]] <= mem_wdata;
      else bad_addr <= bad_addr + 1;
      if (done || err) bad_we <= bad_we + 1;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int t;
    @(negedge clk);
    if (gap > 0 && $urandom_range(99) < gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(2, 1)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] n,
                            input int nw,
                            input logic [2:0][31:0] w,
                            input bit send_cs,
                            input logic [7:0] flip,
                            input int gap);
    logic [7:0] a;
    logic [7:0] b;
    a = n[7:0] ^ n[15:8];
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        b = w[i][8*k +: 8];
        a = a ^ b;
        send_byte(b, gap);
      end
    end
    if (send_cs) send_byte(a ^ flip, gap);
    idle(3);
  endtask

  task automatic pulse_rearm();
    @(negedge clk);
    in_valid = 1'b0;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_ready"}, 32'(in_ready), 32'd1);
    check({p, "_we"}, 32'(mem_we), 32'd0);
    check({p, "_addr"}, 32'(mem_addr), 32'd0);
    check({p, "_wdata"}, mem_wdata, 32'd0);
    check({p, "_cpurst"}, 32'(cpu_reset), 32'd1);
    check({p, "_done"}, 32'(done), 32'd0);
    check({p, "_err"}, 32'(err), 32'd0);
  endtask

  typedef struct {
    string            nm;
    logic [15:0]      n;
    int               nw;
    logic [2:0][31:0] w;
    bit               send_cs;
    logic [7:0]       flip;
    logic             exp_done;
    logic             exp_err;
    int               exp_wr;
  } row_t;

  row_t rows [5];
  logic [2:0][31:0] ws;
  int base;

  initial begin
    rows[0] = '{"one_word", 16'd1, 1,
                {32'd0, 32'd0, 32'h00000013},
                1'b1, 8'h00, 1'b1, 1'b0, 1};
    rows[1] = '{"three_word", 16'd3, 3,
                {32'hDEADBEEF, 32'h55667788,
                 32'h11223344},
                1'b1, 8'h00, 1'b1, 1'b0, 3};
    rows[2] = '{"bad_csum", 16'd3, 3,
                {32'hDEADBEEF, 32'h55667788,
                 32'h11223344},
                1'b1, 8'h01, 1'b0, 1'b1, 3};
    rows[3] = '{"empty", 16'd0, 0,
                {32'd0, 32'd0, 32'd0},
                1'b1, 8'h00, 1'b1, 1'b0, 0};
    rows[4] = '{"too_long", 16'h8001, 0,
                {32'd0, 32'd0, 32'd0},
                1'b0, 8'h00, 1'b0, 1'b1, 0};

    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    for (int r = 0; r < 5; r++) begin
      if (r > 0) pulse_rearm();
      base = wr_cnt;
      send_frame(rows[r].n, rows[r].nw, rows[r].w,
                 rows[r].send_cs, rows[r].flip, 0);
      check({rows[r].nm, "_done"}, 32'(done),
            32'(rows[r].exp_done));
      check({rows[r].nm, "_err"}, 32'(err),
            32'(rows[r].exp_err));
      check({rows[r].nm, "_cpurst"}, 32'(cpu_reset),
            32'(!rows[r].exp_done));
      check({rows[r].nm, "_ready"}, 32'(in_ready), 32'd0);
      check({rows[r].nm, "_writes"}, 32'(wr_cnt - base),
            32'(rows[r].exp_wr));
      for (int i = 0; i < rows[r].exp_wr; i++)
        check({rows[r].nm, "_word"}, mdl[i], rows[r].w[i]);
      if (r == 1)
        for (int i = 1; i < 3; i++)
          check("spacing", 32'(wr_cyc[base + i] -
                               wr_cyc[base + i - 1]), 32'd4);
    end

    pulse_rearm();
    check("rearm_ready", 32'(in_ready), 32'd1);
    check("rearm_err", 32'(err), 32'd0);
    check("rearm_cpurst", 32'(cpu_reset), 32'd1);

    // rearm in the middle of the second word
    base = wr_cnt;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    ws = {32'd0, 32'hCAFEF00D, 32'hA1B2C3D4};
    for (int k = 0; k < 6; k++)
      send_byte(ws[k / 4][8 * (k % 4) +: 8], 0);
    pulse_rearm();
    idle(2);
    check("abort_writes", 32'(wr_cnt - base), 32'd1);
    check("abort_w0", mdl[0], 32'hA1B2C3D4);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    base = wr_cnt;
    ws = {32'd0, 32'h0BADC0DE, 32'h87654321};
    send_frame(16'd2, 2, ws, 1'b1, 8'h00, 0);
    check("reload_writes", 32'(wr_cnt - base), 32'd2);
    check("reload_w0", mdl[0], 32'h87654321);
    check("reload_w1", mdl[1], 32'h0BADC0DE);
    check("reload_done", 32'(done), 32'd1);

    // async reset in the middle of DATA with gaps
    pulse_rearm();
    base = wr_cnt;
    ws = {32'h01020304, 32'hF0E0D0C0, 32'h13579BDF};
    send_byte(8'h03, 50);
    send_byte(8'h00, 50);
    for (int k = 0; k < 5; k++)
      send_byte(ws[k / 4][8 * (k % 4) +: 8], 50);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    check("async_kept", mdl[0], 32'h13579BDF);
    @(negedge clk);
    reset = 1'b1;
    base = wr_cnt;
    ws = {32'h89ABCDEF, 32'h76543210, 32'h00FF00FF};
    send_frame(16'd3, 3, ws, 1'b1, 8'h00, 50);
    check("gap_writes", 32'(wr_cnt - base), 32'd3);
    for (int i = 0; i < 3; i++)
      check("gap_word", mdl[i], ws[i]);
    check("gap_done", 32'(done), 32'd1);
    check("gap_cpurst", 32'(cpu_reset), 32'd0);
    check("we_in_final", 32'(bad_we), 32'd0);
    check("addr_range", 32'(bad_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
